// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC definitions.
//   pkt_state_e : packet framing state of a flit sender (IDLE / IN_PKT).
//   credit_w()  : width of a credit counter able to hold 0..depth inclusive.
package noc_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } pkt_state_e;

    function automatic int credit_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/credit_counter.sv
// credit_counter: up/down credit counter that saturates at DEPTH.
//   clk, rst_n : clock and asynchronous active-low reset (count -> DEPTH)
//   inc        : one credit returned this cycle
//   dec        : one credit consumed this cycle
//   count      : current credit count, 0..DEPTH
//   overflow   : sticky flag, set when inc arrives with the counter full
//                and nothing consumed in the same cycle
module credit_counter
    import noc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       inc,
    input  logic                       dec,
    output logic [credit_w(DEPTH)-1:0] count,
    output logic                       overflow
);

    localparam int             CW  = credit_w(DEPTH);
    localparam logic [CW-1:0]  MAX = CW'(DEPTH);

    logic [CW-1:0] cnt_p0;
    logic [CW-1:0] cnt_next;
    logic          ovf_p0;
    logic          ovf_hit;

    // Saturating step: never exceeds MAX, never wraps below zero.
    function automatic logic [CW-1:0] sat_step(input logic [CW-1:0] c,
                                               input logic          up,
                                               input logic          dn);
        logic [CW-1:0] r;
        r = c;
        case ({up, dn})
            2'b10:   r = (c == MAX) ? c : c + 1'b1;
            2'b01:   r = (c == '0)  ? c : c - 1'b1;
            default: r = c;
        endcase
        return r;
    endfunction

    always_comb begin
        cnt_next = sat_step(cnt_p0, inc, dec);
        ovf_hit  = inc && !dec && (cnt_p0 == MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p0 <= MAX;
            ovf_p0 <= 1'b0;
        end else begin
            cnt_p0 <= cnt_next;
            if (ovf_hit) begin
                ovf_p0 <= 1'b1;
            end
        end
    end

    assign count    = cnt_p0;
    assign overflow = ovf_p0;

endmodule

// File: rtl/flit_credit_sender.sv
// flit_credit_sender: credit-based flit injector towards a NoC router.
//   clk_noc, rst_n       : clock, asynchronous active-low reset
//   in_valid/in_ready    : local flit handshake; ready iff credits remain
//   in_data/in_dest      : flit payload and destination (dest used on heads)
//   in_is_tail           : marks the last flit of a packet
//   data_out, dest_out,
//   is_tail_out, send_out: registered router-side link, send_out one cycle
//                          per accepted flit
//   credit_in            : one credit returned per high cycle
//   credits_avail        : current credit count
//   err_credit_overflow  : sticky, credit returned while already full
module flit_credit_sender
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH        = 64,
    parameter int DEST_WIDTH        = 4,
    parameter int FLIT_BUFFER_DEPTH = 8
) (
    input  logic                                   clk_noc,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [FLIT_WIDTH-1:0]                  in_data,
    input  logic [DEST_WIDTH-1:0]                  in_dest,
    input  logic                                   in_is_tail,
    output logic [FLIT_WIDTH-1:0]                  data_out,
    output logic [DEST_WIDTH-1:0]                  dest_out,
    output logic                                   is_tail_out,
    output logic                                   send_out,
    input  logic                                   credit_in,
    output logic [credit_w(FLIT_BUFFER_DEPTH)-1:0] credits_avail,
    output logic                                   err_credit_overflow
);

    pkt_state_e            state_q;
    pkt_state_e            state_d;
    logic                  accept;
    logic                  is_head;

    logic [FLIT_WIDTH-1:0] data_p1;
    logic [DEST_WIDTH-1:0] dest_p1;
    logic                  tail_p1;
    logic                  vld_p1;

    // Gating ready on the registered count keeps sends <= credits held.
    assign in_ready = (credits_avail != '0);
    assign accept   = in_valid && in_ready;
    assign is_head  = (state_q == IDLE);

    credit_counter #(
        .DEPTH (FLIT_BUFFER_DEPTH)
    ) u_credit_counter (
        .clk      (clk_noc),
        .rst_n    (rst_n),
        .inc      (credit_in),
        .dec      (accept),
        .count    (credits_avail),
        .overflow (err_credit_overflow)
    );

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                IDLE:    state_d = in_is_tail ? IDLE : IN_PKT;
                IN_PKT:  state_d = in_is_tail ? IDLE : IN_PKT;
                default: state_d = IDLE;
            endcase
        end
    end

    // ---- stage p1: registered router link ----
    // dest_p1 is only loaded on heads, so body flits reuse the head's dest.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            dest_p1 <= '0;
            tail_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                data_p1 <= in_data;
                tail_p1 <= in_is_tail;
                if (is_head) begin
                    dest_p1 <= in_dest;
                end
            end
        end
    end

    assign send_out    = vld_p1;
    assign data_out    = data_p1;
    assign dest_out    = dest_p1;
    assign is_tail_out = tail_p1;

endmodule

// File: doc/flit_credit_sender.md
FLIT_CREDIT_SENDER -- requirements
Module: flit_credit_sender

Interface
REQ-001 SHALL have parameter FLIT_WIDTH, default 64, flit payload width.
REQ-002 SHALL have parameter DEST_WIDTH, default 4, destination field width (TDEST+TID).
REQ-003 SHALL have parameter FLIT_BUFFER_DEPTH, default 8, downstream input buffer depth and initial credit count.
REQ-004 SHALL have port clk_noc, input, 1, the single clock; all logic in this block is on this clock.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, local flit offered.
REQ-007 SHALL have port in_ready, output, 1, local flit accepted this cycle when in_valid is also high.
REQ-008 SHALL have port in_data, input, FLIT_WIDTH, local flit payload.
REQ-009 SHALL have port in_dest, input, DEST_WIDTH, destination, sampled on head flits only.
REQ-010 SHALL have port in_is_tail, input, 1, last flit of packet.
REQ-011 SHALL have ports data_out, dest_out, is_tail_out, send_out, outputs, FLIT_WIDTH/DEST_WIDTH/1/1, router-side flit link.
REQ-012 SHALL have port credit_in, input, 1, one credit returned by the downstream router per high cycle.
REQ-013 SHALL have port credits_avail, output, $clog2(FLIT_BUFFER_DEPTH+1), current credit count.
REQ-014 SHALL have port err_credit_overflow, output, 1, sticky error flag.

Function
REQ-015 SHALL assert in_ready combinationally iff credits_avail != 0.
REQ-016 SHALL accept a flit on the cycle in_valid && in_ready, and present it registered on the next cycle with send_out=1 for exactly one cycle.
REQ-017 SHALL drive send_out=0 in any cycle following no acceptance; data_out/dest_out/is_tail_out hold their last values.
REQ-018 SHALL update credits next = credits - accept + credit_in; simultaneous accept and credit_in leaves the count unchanged.
REQ-019 SHALL saturate credits at FLIT_BUFFER_DEPTH; credit_in that would exceed it SHALL set err_credit_overflow, which stays set until reset.
REQ-020 SHALL implement packet FSM with states IDLE and IN_PKT: IDLE->IN_PKT on accepted non-tail flit; IN_PKT->IDLE on accepted tail; an accepted tail flit in IDLE (single-flit packet) stays in IDLE.
REQ-021 SHALL capture in_dest on every flit accepted in IDLE, and drive dest_out from the captured value for all flits of that packet, ignoring in_dest during IN_PKT.
REQ-022 SHALL sustain one flit per cycle while credits remain; with zero credits, in_ready deasserts and the first flit after a credit_in is accepted in the same cycle credit becomes nonzero on the register.
REQ-023 SHALL never assert send_out more times than credits held, so the downstream buffer cannot overflow.

Reset
REQ-024 SHALL, while rst_n is low, asynchronously force send_out=0, is_tail_out=0, data_out=0, dest_out=0, err_credit_overflow=0, FSM=IDLE, credits=FLIT_BUFFER_DEPTH.
REQ-025 SHALL, on reset mid-packet, discard the partial packet; the first post-reset flit is treated as a head.

Structure
REQ-026 SHALL place the FSM state enum (IDLE, IN_PKT) and credit-width function in shared package noc_pkg.
REQ-027 SHALL use one sub-module, credit_counter (up/down saturating counter with overflow flag), instantiated once.

Verification
REQ-028 Reset, then in_valid held high with 10 single-flit packets (tail=1) and no credit_in -> exactly 8 send_out pulses, in_ready low afterwards, credits_avail=0.
REQ-029 At credits=0, pulse credit_in once with in_valid high -> credits_avail=1 next cycle, one flit accepted, send_out pulse one cycle after acceptance.
REQ-030 4-flit packet, in_dest=0x3 on head then 0x9,0xA,0xB on body -> all four outputs carry dest_out=0x3, is_tail_out=1 only on the fourth.
REQ-031 Accept and credit_in in the same cycle at credits=5 -> credits_avail stays 5.
REQ-032 At credits=8 with no traffic, pulse credit_in -> err_credit_overflow=1 and credits_avail stays 8 until rst_n low.
REQ-033 Assert rst_n low after the 2nd flit of a 4-flit packet -> outputs zero immediately, credits=8; next flit with in_dest=0x5 emits dest_out=0x5.
